proc_core: RTL and testbench
============================

// Module: proc_core
// PURPOSE
//  Multi-cycle 16-bit processor core: control FSM, 16x16 register file and ALU.
//  Fetches from an external synchronous instruction ROM, executes one instruction every 4 cycles.
//  Exposes a write-back trace port for checking.
//  Sits under the top level, between the instruction memory and board I/O.
// PARAMETERS
//  none (widths fixed: data 16, PC 12, register index 4)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-low
//  instr_i    in   16  ROM data; valid one cycle after pc_o changes (sync ROM)
//  pc_o       out  12  instruction address (the PC register)
//  wb_en_o    out  1   register write strobe this cycle
//  wb_reg_o   out  4   destination index
//  wb_data_o  out  16  value written
//  zero_o     out  1   last ALU result == 0
//  halted_o   out  1   core stopped on HALT
// BEHAVIOUR
//  Reset (reset=0, async): PC=0, IR=0, all 16 regs=0, FSM=FETCH, all outputs 0.
//  Instruction format: op[15:12] rc[11:8] ra[7:4] rb[3:0]; imm4=[3:0], imm12=[11:0].
//  FSM, one state per cycle: FETCH -> DECODE -> EXEC -> WB -> FETCH.
//  - FETCH: pc_o stable.
//  - DECODE: IR<=instr_i; A<=R[ra]; B<=R[rb].
//  - EXEC: ALU result registered into Y; zero_o<=(Y_next==0), updated only here.
//  - WB: write R[rc]<=Y if op writes; wb_* valid for exactly this cycle; PC updated.
//  Opcodes (Y, all arithmetic mod 2^16):
//  - 0 ADD A+B | 1 SUB A-B | 2 AND | 3 OR | 4 XOR
//  - 5 SLL A<<B[3:0] | 6 SRL A>>B[3:0] (logical)
//  - 7 SLT unsigned (A<B)?1:0 | 8 ADDI A+zext(imm4)
//  - C MULL low16(A*B) | D MULH high16(A*B), unsigned 32-bit product
//  - 9 BEQZ: if A==0 then PC<=B[11:0] else PC+1; no write
//  - A JMP: PC<=imm12; no write
//  - B,E NOP: PC+1
//  - F HALT: FSM->HALTED, PC unchanged, halted_o=1 until reset
//  Other opcodes: PC<=PC+1 in WB.
//  PC increment wraps 0xFFF->0x000.
//  Writing rc==ra is allowed: operands were latched in DECODE.
//  R0 is an ordinary register, writable.
//  Reset asserted in any state aborts the instruction; no partial register write.
// STRUCTURE
//  Shared package proc_pkg: opcode localparams, FSM state encoding
//  (FETCH, DECODE, EXEC, WB, HALTED), field bit positions.
//  One natural sub-module: core_alu (combinational; op, a, b -> y, zero).
//  Register file and FSM stay inline in proc_core.
// TESTING
//  - Program ADDI R1,R0,5 (0x8105): wb_en_o pulses in cycle 4 after reset release
//    with wb_reg_o=1, wb_data_o=0x0005; pc_o=1 afterwards.
//  - SUB R2,R0,R1 with R1=1: R2=0xFFFF, zero_o=0.
//  - SUB R3,R1,R1: R3=0x0000, zero_o=1.
//  - R4=0x8000, R5=4; MULL R6,R4,R5 -> 0x0000; MULH R7,R4,R5 -> 0x0002.
//  - BEQZ with R[ra]=0, R[rb]=0x020: pc_o=0x020.
//  - BEQZ with R[ra]=1: pc_o=old+1.
//  - JMP 0xFFF: pc_o=0xFFF; following NOP wraps pc_o to 0x000.
//  - HALT: halted_o=1, pc_o frozen for 20 cycles.
//  - Reset pulse mid-EXEC: outputs 0 immediately.
//  - After any reset pulse: all regs read back 0.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, FSM states and instruction field positions
package proc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_NOPB = 4'hB;
  localparam logic [3:0] OP_MULL = 4'hC;
  localparam logic [3:0] OP_MULH = 4'hD;
  localparam logic [3:0] OP_NOPE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RC_MSB = 11;
  localparam int RC_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_ADDI) || (op == OP_MULL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - combinational 16-bit ALU
module core_alu
  import proc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y,
  output logic        zero
);

  logic [31:0] prod;

  assign prod = 32'(a) * 32'(b);

  // ADDI arrives here as an add: the top substitutes zext(imm4) for b
  always_comb begin
    y = '0;
    case (op)
      OP_ADD, OP_ADDI: y = a + b;
      OP_SUB:          y = a - b;
      OP_AND:          y = a & b;
      OP_OR:           y = a | b;
      OP_XOR:          y = a ^ b;
      OP_SLL:          y = a << b[3:0];
      OP_SRL:          y = a >> b[3:0];
      OP_SLT:          y = {15'b0, a < b};
      OP_MULL:         y = prod[15:0];
      OP_MULH:         y = prod[31:16];
      default:         y = '0;
    endcase
  end

  assign zero = (y == 16'h0000);

endmodule

// File: rtl/proc_core.sv
// rtl/proc_core.sv - multi-cycle 16-bit core: FSM, 16x16 register file, ALU
module proc_core
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_i,
  output logic [11:0] pc_o,
  output logic        wb_en_o,
  output logic [3:0]  wb_reg_o,
  output logic [15:0] wb_data_o,
  output logic        zero_o,
  output logic        halted_o
);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] y_q;
  logic [15:0] regs [16];

  logic [3:0]  op;
  logic [3:0]  rc;
  logic [15:0] alu_b;
  logic [15:0] alu_y;
  logic        alu_zero;

  assign op    = ir[OP_MSB:OP_LSB];
  assign rc    = ir[RC_MSB:RC_LSB];
  assign alu_b = (op == OP_ADDI) ? {12'b0, ir[RB_MSB:RB_LSB]} : b_q;

  core_alu u_alu (
    .op   (op),
    .a    (a_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc_o      <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      wb_en_o   <= 1'b0;
      wb_reg_o  <= '0;
      wb_data_o <= '0;
      zero_o    <= 1'b0;
      halted_o  <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      // trace outputs are single-cycle: only the EXEC->WB edge raises them
      wb_en_o   <= 1'b0;
      wb_reg_o  <= '0;
      wb_data_o <= '0;
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= instr_i;
          a_q   <= regs[instr_i[RA_MSB:RA_LSB]];
          b_q   <= regs[instr_i[RB_MSB:RB_LSB]];
          state <= EXEC;
        end
        EXEC: begin
          y_q    <= alu_y;
          zero_o <= alu_zero;
          if (op_writes(op)) begin
            wb_en_o   <= 1'b1;
            wb_reg_o  <= rc;
            wb_data_o <= alu_y;
          end
          state <= WB;
        end
        WB: begin
          if (op_writes(op)) regs[rc] <= y_q;
          case (op)
            OP_BEQZ: pc_o <= (a_q == 16'h0000) ? b_q[11:0] : pc_o + 12'd1;
            OP_JMP:  pc_o <= ir[11:0];
            OP_HALT: pc_o <= pc_o;
            default: pc_o <= pc_o + 12'd1;
          endcase
          if (op == OP_HALT) begin
            state    <= HALTED;
            halted_o <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// tb/tb_proc_core.sv - directed scoreboard bench for proc_core
module tb_proc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr;
  logic [11:0] pc;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        zero;
  logic        halted;

  logic [15:0] rom [4096];

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } wb_t;

  wb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  proc_core dut (
    .clk       (clk),
    .reset     (reset),
    .instr_i   (instr),
    .pc_o      (pc),
    .wb_en_o   (wb_en),
    .wb_reg_o  (wb_reg),
    .wb_data_o (wb_data),
    .zero_o    (zero),
    .halted_o  (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [11:0] addr, input logic [15:0] w, input logic wr, input logic [15:0] d);
    wb_t e;
    rom[addr] = w;
    if (wr) begin
      e.r = w[11:8];
      e.d = d;
      sb.push_back(e);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 16'hB000;
  endtask

  task automatic pop_check(input string tag);
    wb_t e;
    check({tag, "_en"}, {15'b0, wb_en}, 16'h0001);
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_reg"}, {12'b0, wb_reg}, {12'b0, e.r});
      check({tag, "_data"}, wb_data, e.d);
    end
  endtask

  task automatic wait_wb(input string tag);
    int n = 1;
    @(negedge clk);
    while (wb_en !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    pop_check(tag);
  endtask

  task automatic load_prog1();
    put(12'h000, 16'h8105, 1'b1, 16'h0005);
    put(12'h001, 16'h8101, 1'b1, 16'h0001);
    put(12'h002, 16'h1201, 1'b1, 16'hFFFF);
    put(12'h003, 16'h1311, 1'b1, 16'h0000);
    put(12'h004, 16'h8401, 1'b1, 16'h0001);
    put(12'h005, 16'h850F, 1'b1, 16'h000F);
    put(12'h006, 16'h5445, 1'b1, 16'h8000);
    put(12'h007, 16'h8504, 1'b1, 16'h0004);
    put(12'h008, 16'hC645, 1'b1, 16'h0000);
    put(12'h009, 16'hD745, 1'b1, 16'h0002);
    put(12'h00A, 16'h2825, 1'b1, 16'h0004);
    put(12'h00B, 16'h3945, 1'b1, 16'h8004);
    put(12'h00C, 16'h4A24, 1'b1, 16'h7FFF);
    put(12'h00D, 16'h6B45, 1'b1, 16'h0800);
    put(12'h00E, 16'h7C54, 1'b1, 16'h0001);
    put(12'h00F, 16'h7D45, 1'b1, 16'h0000);
    put(12'h010, 16'h0E24, 1'b1, 16'h7FFF);
    put(12'h011, 16'h8F02, 1'b1, 16'h0002);
    put(12'h012, 16'h5FF5, 1'b1, 16'h0020);
    put(12'h013, 16'h900F, 1'b0, 16'h0000);
    put(12'h020, 16'h911F, 1'b0, 16'h0000);
    put(12'h021, 16'h8111, 1'b1, 16'h0002);
    put(12'h022, 16'hAFFF, 1'b0, 16'h0000);
  endtask

  initial begin
    clear_rom();
    load_prog1();
    repeat (3) @(negedge clk);
    check("rst_pc", {4'b0, pc}, 16'h0000);
    check("rst_wb_en", {15'b0, wb_en}, 16'h0000);
    check("rst_wb_reg", {12'b0, wb_reg}, 16'h0000);
    check("rst_wb_data", wb_data, 16'h0000);
    check("rst_zero", {15'b0, zero}, 16'h0000);
    check("rst_halted", {15'b0, halted}, 16'h0000);

    reset = 1'b1;
    @(negedge clk);
    check("addi_c2_en", {15'b0, wb_en}, 16'h0000);
    @(negedge clk);
    check("addi_c3_en", {15'b0, wb_en}, 16'h0000);
    @(negedge clk);
    pop_check("addi_r1_5");
    rom[0] = 16'hF000;
    @(negedge clk);
    check("addi_pc", {4'b0, pc}, 16'h0001);

    wait_wb("addi_r1_1");
    wait_wb("sub_r2");
    check("sub_r2_zero", {15'b0, zero}, 16'h0000);
    wait_wb("sub_r3");
    check("sub_r3_zero", {15'b0, zero}, 16'h0001);
    for (int i = 4; i <= 18; i++) wait_wb($sformatf("alu_%0d", i));

    repeat (5) @(negedge clk);
    check("beqz_taken_pc", {4'b0, pc}, 16'h0020);
    repeat (4) @(negedge clk);
    check("beqz_not_taken_pc", {4'b0, pc}, 16'h0021);
    wait_wb("addi_rc_eq_ra");
    repeat (5) @(negedge clk);
    check("jmp_pc", {4'b0, pc}, 16'h0FFF);
    repeat (4) @(negedge clk);
    check("nop_wrap_pc", {4'b0, pc}, 16'h0000);
    repeat (4) @(negedge clk);
    check("halt_flag", {15'b0, halted}, 16'h0001);
    check("halt_pc", {4'b0, pc}, 16'h0000);
    repeat (20) @(negedge clk);
    check("halt_flag_20", {15'b0, halted}, 16'h0001);
    check("halt_pc_20", {4'b0, pc}, 16'h0000);
    check("halt_wb_en_20", {15'b0, wb_en}, 16'h0000);
    check("prog1_sb_drained", 16'(sb.size()), 16'h0000);

    reset = 1'b0;
    sb.delete();
    load_prog1();
    @(negedge clk);
    check("rst2_halted", {15'b0, halted}, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) wait_wb($sformatf("rerun_%0d", i));
    repeat (3) @(negedge clk);
    check("exec_pre_pc", {4'b0, pc}, 16'h0004);
    check("exec_pre_zero", {15'b0, zero}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    check("exec_rst_pc", {4'b0, pc}, 16'h0000);
    check("exec_rst_zero", {15'b0, zero}, 16'h0000);
    check("exec_rst_wb_en", {15'b0, wb_en}, 16'h0000);
    check("exec_rst_wb_data", wb_data, 16'h0000);
    check("exec_rst_halted", {15'b0, halted}, 16'h0000);

    sb.delete();
    clear_rom();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] r;
      r = 4'(i);
      put(12'(i), {4'h3, r, r, r}, 1'b1, 16'h0000);
    end
    put(12'h010, 16'hF000, 1'b0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) wait_wb($sformatf("readback_r%0d", i));
    check("readback_zero", {15'b0, zero}, 16'h0001);
    repeat (5) @(negedge clk);
    check("readback_halted", {15'b0, halted}, 16'h0001);
    check("readback_halt_pc", {4'b0, pc}, 16'h0010);
    check("readback_sb_drained", 16'(sb.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
